// File: rtl/player_bullet.sv
// Player projectile engine: launches one bullet from the ship centre, steps it upward, retires it on hit/top/death.
// Optional build macro PLAYER_BULLET_AUTOFIRE_EN: a held shoot button relaunches whenever the engine is idle.
module player_bullet #(
    parameter logic [9:0]  start_row_p  = 10'd440,
    parameter logic [9:0]  screen_top_p = 10'd32,
    parameter int unsigned step_px_p    = 4,
    parameter int unsigned tick_div_p   = 250000,
    parameter int unsigned cooldown_p   = 2500000
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       shoot_i,
    input  logic       alive_i,
    input  logic       pause_i,
    input  logic [9:0] pos_left_i,
    input  logic [9:0] pos_right_i,
    input  logic       hit_enemy_i,
    output logic       active_o,
    output logic [9:0] bullet_x_o,
    output logic [9:0] bullet_y_o,
    output logic       fired_o,
    output logic       kill_o,
    output logic       miss_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FLY      = 2'd1;
    localparam logic [1:0] COOLDOWN = 2'd2;

    localparam int DIV_W  = $clog2(tick_div_p);
    localparam int COOL_W = $clog2(cooldown_p + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(tick_div_p - 1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(cooldown_p - 1);
    localparam logic [9:0]        STEP      = 10'(step_px_p);
    localparam logic [10:0]       MISS_LIM  = {1'b0, screen_top_p} + 11'(step_px_p);

    // Sum is formed at 11 bits so ships near the right edge do not wrap.
    function automatic logic [9:0] centre_x(input logic [9:0] left, input logic [9:0] right);
        logic [10:0] sum;
        sum = {1'b0, left} + {1'b0, right};
        return sum[10:1];
    endfunction

    logic [1:0]        state_q, state_d;
    logic              shoot_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [COOL_W-1:0] cool_q, cool_d;
    logic [9:0]        x_d, y_d;
    logic              active_d, fired_d, kill_d, miss_d;
    logic              launch_req;

`ifdef PLAYER_BULLET_AUTOFIRE_EN
    assign launch_req = shoot_i;
`else
    assign launch_req = shoot_i & ~shoot_q;
`endif

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cool_d   = cool_q;
        x_d      = bullet_x_o;
        y_d      = bullet_y_o;
        active_d = active_o;
        fired_d  = 1'b0;
        kill_d   = 1'b0;
        miss_d   = 1'b0;
        case (state_q)
            IDLE: begin
                y_d = start_row_p;
                if (launch_req && alive_i && !pause_i) begin
                    state_d  = FLY;
                    x_d      = centre_x(pos_left_i, pos_right_i);
                    div_d    = '0;
                    active_d = 1'b1;
                    fired_d  = 1'b1;
                end
            end
            FLY: begin
                if (!alive_i) begin
                    state_d  = IDLE;
                    y_d      = start_row_p;
                    active_d = 1'b0;
                end else if (hit_enemy_i) begin
                    state_d  = COOLDOWN;
                    cool_d   = COOL_LOAD;
                    active_d = 1'b0;
                    kill_d   = 1'b1;
                end else if (!pause_i) begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if ({1'b0, bullet_y_o} < MISS_LIM) begin
                            state_d  = COOLDOWN;
                            cool_d   = COOL_LOAD;
                            active_d = 1'b0;
                            miss_d   = 1'b1;
                        end else begin
                            y_d = bullet_y_o - STEP;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            COOLDOWN: begin
                if (!alive_i || (!pause_i && cool_q == '0)) begin
                    state_d = IDLE;
                    y_d     = start_row_p;
                end else if (!pause_i) begin
                    cool_d = cool_q - 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                y_d      = start_row_p;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            shoot_q    <= 1'b0;
            div_q      <= '0;
            cool_q     <= '0;
            bullet_x_o <= '0;
            bullet_y_o <= start_row_p;
            active_o   <= 1'b0;
            fired_o    <= 1'b0;
            kill_o     <= 1'b0;
            miss_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shoot_q    <= shoot_i;
            div_q      <= div_d;
            cool_q     <= cool_d;
            bullet_x_o <= x_d;
            bullet_y_o <= y_d;
            active_o   <= active_d;
            fired_o    <= fired_d;
            kill_o     <= kill_d;
            miss_o     <= miss_d;
        end
    end

endmodule

// File: doc/player_bullet.md
# player_bullet

Player projectile engine for the space-invaders datapath. Sits directly downstream of `player`. It consumes the player's shoot button, alive flag and left/right ship extents, and launches a single bullet from the ship's centre. It steps the bullet upward at a fixed rate and retires it on an enemy hit, on reaching the top of the playfield, or on player death, then enforces a cooldown. Its outputs feed the collision checker, the score counter and the video renderer.

## Interface
Parameters:
- `start_row_p`, 10'd440: launch Y row (just above ship).
- `screen_top_p`, 10'd32: topmost row the bullet may occupy.
- `step_px_p`, 4: pixels moved upward per step; 1..15.
- `tick_div_p`, 250000: clock cycles per step; >=2.
- `cooldown_p`, 2500000: cycles after retire before next launch; >=1.

Ports:
- `clk_i`  in  1  system clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `shoot_i`  in  1  debounced shoot button (level).
- `alive_i`  in  1  `player` alive_o.
- `pause_i`  in  1  freeze (level paused or lost-life hold).
- `pos_left_i`  in  10  `player` pos_left_o.
- `pos_right_i`  in  10  `player` pos_right_o.
- `hit_enemy_i`  in  1  collision checker: bullet overlaps live enemy.
- `active_o`  out  1  bullet on screen.
- `bullet_x_o`  out  10  bullet column.
- `bullet_y_o`  out  10  bullet row (top pixel).
- `fired_o`  out  1  one-cycle pulse, first cycle active_o high.
- `kill_o`  out  1  one-cycle pulse, bullet retired by hit.
- `miss_o`  out  1  one-cycle pulse, bullet retired at top.

## Operation
- Reset: state IDLE. All outputs 0. `bullet_x_o`=0, `bullet_y_o`=`start_row_p`. Divider 0, cooldown 0, `shoot_q`=0.
- Launch request: `shoot_i & ~shoot_q`. `shoot_q` is registered every cycle.
- IDLE -> FLY when launch request & `alive_i` & ~`pause_i`.
  - X latches `(pos_left_i + pos_right_i) >> 1`, computed at 11 bits then truncated.
  - Y loads `start_row_p`. Divider clears.
- FLY:
  - Divider counts while ~`pause_i`; at `tick_div_p-1` it wraps to 0 (step event).
  - On a step event, if `y < screen_top_p + step_px_p` -> COOLDOWN with `miss_o`; otherwise `y -= step_px_p`.
  - X is frozen for the whole flight.
- Priority inside FLY: ~`alive_i` > `hit_enemy_i` > step event.
  - ~`alive_i` -> IDLE directly, no pulse, no cooldown.
  - `hit_enemy_i` -> COOLDOWN with `kill_o`. A same-cycle step is discarded.
- `hit_enemy_i` is ignored outside FLY. It is honoured in FLY even while paused.
- COOLDOWN: counter loads `cooldown_p-1` on entry, decrements while ~`pause_i`, and goes to IDLE at 0. ~`alive_i` forces IDLE immediately.
- Launch requests in FLY/COOLDOWN are dropped, not queued. A held button requires release and re-press.
- `bullet_y_o` returns to `start_row_p` on any entry to IDLE.

## Timing
- All outputs registered.
- Launch request sampled at edge N -> `active_o`=1, `fired_o`=1 after edge N. `fired_o`=0 after N+1.
- First step occurs `tick_div_p` cycles after launch (pause excluded).
- `hit_enemy_i` high at edge N -> `active_o`=0, `kill_o`=1 after edge N.
- Async reset mid-flight clears everything immediately. Deassertion is synchronised externally.

## Configuration
- `PLAYER_BULLET_AUTOFIRE_EN`:
  - Defined: the launch request is the level `shoot_i`, so a held button relaunches as soon as IDLE is reached.
  - Undefined: rising edge only, as above.

## Test plan
Params: start 40, top 32, step 4, tick 4, cooldown 8.
- Ship 100..115, shoot pulse -> next cycle `fired_o`=1, X=107, Y=40; Y=36 after 4 cycles, Y=32 after 8; at the 12th cycle `miss_o`=1, `active_o`=0; 8 cycles later IDLE.
- `hit_enemy_i` asserted at Y=36, same cycle as step -> `kill_o`=1, Y stays 36, no `miss_o`.
- `pause_i` held 10 cycles mid-flight -> Y and divider frozen; flight resumes with the remaining count.
- Shoot held through the whole flight and cooldown -> no relaunch (autofire off); relaunch after the button is released and pressed again.
- `alive_i` dropped mid-flight -> `active_o`=0 next cycle, no pulses, immediate relaunch allowed once alive.
- `reset_n_i` asserted mid-flight -> all outputs 0 and Y=40 without a clock edge.
